// File: rtl/reaction_sequencer.sv
// Reaction-time game sequencer: waits a pseudo-random delay, lights the go LED,
// times the player's stop press via an external ms counter and tracks the best
// time over a fixed number of rounds.
module reaction_sequencer #(
    parameter int TICKS_PER_MS = 50000,
    parameter int ROUNDS       = 4,
    parameter int DELAY_MIN_MS = 2000
) (
    input  logic       clk_50M,
    input  logic       clear,
    input  logic       start,
    input  logic       stop,
    input  logic [9:0] counter_value,
    output logic [1:0] CounterFlag,
    output logic       LED,
    output logic       foul,
    output logic [1:0] round_idx,
    output logic       result_valid,
    output logic [9:0] result_time,
    output logic [9:0] best_time,
    output logic       done
);

    localparam int          PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [1:0]  LAST_ROUND = 2'(ROUNDS - 1);
    localparam logic [9:0]  T_MAX      = 10'd999;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_DELAY, S_TIMING, S_CAPTURE, S_ROUND_END, S_DONE
    } state_t;

    state_t      r_state, w_state_next;
    logic [15:0] r_lfsr;
    logic [PW-1:0] r_presc;
    logic [15:0] r_delay, w_delay_next;
    logic        r_cap, w_cap_next;
    logic [1:0]  r_round, w_round_next;
    logic        r_foul, w_foul_next;
    logic        r_rv, w_rv_next;
    logic [9:0]  r_rt, w_rt_next;
    logic [9:0]  r_best, w_best_next;
    logic [1:0]  r_valid;
    logic [1:0]  w_btn;
    logic [1:0]  w_edge;
    logic        w_start_edge, w_stop_edge, w_tick;
    logic [15:0] w_delay_load;

    assign w_btn        = {stop, start};
    assign w_start_edge = w_edge[0];
    assign w_stop_edge  = w_edge[1];
    assign w_tick       = (r_presc == PW'(TICKS_PER_MS - 1));
    assign w_delay_load = 16'(DELAY_MIN_MS) + {4'b0, r_lfsr[11:0]};

    // Marks when the synchronizer outputs carry real post-reset samples.
    always_ff @(posedge clk_50M or negedge clear) begin
        if (!clear) r_valid <= 2'b00;
        else        r_valid <= {r_valid[0], 1'b1};
    end

    // Button conditioning: 2-flop sync, then a registered rising-edge detector.
    // An edge is only armed once a genuine low level has been seen, so a button
    // held through reset release does not fire.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic r_s1, r_s2, r_dly, r_arm, r_edge;
            // Synchronize, delay and detect the rising edge of one button.
            always_ff @(posedge clk_50M or negedge clear) begin
                if (!clear) begin
                    r_s1   <= 1'b0;
                    r_s2   <= 1'b0;
                    r_dly  <= 1'b0;
                    r_arm  <= 1'b0;
                    r_edge <= 1'b0;
                end else begin
                    r_s1   <= w_btn[gi];
                    r_s2   <= r_s1;
                    r_dly  <= r_s2;
                    r_arm  <= r_arm | (r_valid[1] & ~r_s2);
                    r_edge <= r_s2 & ~r_dly & r_arm;
                end
            end
            assign w_edge[gi] = r_edge;
        end
    endgenerate

    // Free-running Galois LFSR (x^16+x^14+x^13+x^11+1) for the random delay.
    always_ff @(posedge clk_50M or negedge clear) begin
        if (!clear) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Millisecond prescaler, restarted on every state change.
    always_ff @(posedge clk_50M or negedge clear) begin
        if (!clear)                       r_presc <= '0;
        else if (w_state_next != r_state) r_presc <= '0;
        else if (w_tick)                  r_presc <= '0;
        else                              r_presc <= r_presc + 1'b1;
    end

    // State and datapath registers.
    always_ff @(posedge clk_50M or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_delay <= '0;
            r_cap   <= 1'b0;
            r_round <= '0;
            r_foul  <= 1'b0;
            r_rv    <= 1'b0;
            r_rt    <= '0;
            r_best  <= T_MAX;
        end else begin
            r_state <= w_state_next;
            r_delay <= w_delay_next;
            r_cap   <= w_cap_next;
            r_round <= w_round_next;
            r_foul  <= w_foul_next;
            r_rv    <= w_rv_next;
            r_rt    <= w_rt_next;
            r_best  <= w_best_next;
        end
    end

    // Next-state, datapath updates and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        w_delay_next = r_delay;
        w_cap_next   = 1'b0;
        w_round_next = r_round;
        w_foul_next  = r_foul;
        w_rv_next    = 1'b0;
        w_rt_next    = r_rt;
        w_best_next  = r_best;
        CounterFlag  = 2'b00;
        LED          = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (r_state == S_DONE) begin
                    CounterFlag = 2'b01;
                    done        = 1'b1;
                end
                if (w_start_edge) begin
                    w_round_next = '0;
                    w_best_next  = T_MAX;
                    w_foul_next  = 1'b0;
                    w_delay_next = w_delay_load;
                    w_state_next = S_WAIT_DELAY;
                end
            end
            S_WAIT_DELAY: begin
                // A stop press wins over a simultaneous delay expiry.
                if (w_stop_edge) begin
                    w_foul_next  = 1'b1;
                    w_rt_next    = T_MAX;
                    w_rv_next    = 1'b1;
                    w_state_next = S_ROUND_END;
                end else if (w_tick) begin
                    if (r_delay <= 16'd1) begin
                        w_delay_next = '0;
                        w_state_next = S_TIMING;
                    end else begin
                        w_delay_next = r_delay - 16'd1;
                    end
                end
            end
            S_TIMING: begin
                CounterFlag = 2'b10;
                LED         = 1'b1;
                if (w_stop_edge) begin
                    w_state_next = S_CAPTURE;
                end else if (counter_value == T_MAX) begin
                    w_rt_next    = T_MAX;
                    w_rv_next    = 1'b1;
                    w_state_next = S_ROUND_END;
                end
            end
            S_CAPTURE: begin
                // First cycle lets the held counter settle; sample on the second.
                CounterFlag = 2'b01;
                if (!r_cap) begin
                    w_cap_next = 1'b1;
                end else begin
                    w_rt_next   = counter_value;
                    w_rv_next   = 1'b1;
                    w_foul_next = 1'b0;
                    if (counter_value < r_best) w_best_next = counter_value;
                    w_state_next = S_ROUND_END;
                end
            end
            S_ROUND_END: begin
                CounterFlag = 2'b01;
                if (r_round == LAST_ROUND) begin
                    w_state_next = S_DONE;
                end else if (w_start_edge) begin
                    w_round_next = r_round + 2'd1;
                    w_foul_next  = 1'b0;
                    w_delay_next = w_delay_load;
                    w_state_next = S_WAIT_DELAY;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign foul         = r_foul;
    assign round_idx    = r_round;
    assign result_valid = r_rv;
    assign result_time  = r_rt;
    assign best_time    = r_best;

endmodule

// File: tb/tb_reaction_sequencer.sv
// Self-checking bench for reaction_sequencer with a result scoreboard.
module tb_reaction_sequencer;

    localparam int TICKS = 4;
    localparam int ROUNDS = 2;
    localparam int DMIN = 2000;

    logic       clk_50M = 1'b0;
    logic       clear = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [9:0] counter_value = 10'd0;
    logic [1:0] CounterFlag;
    logic       LED;
    logic       foul;
    logic [1:0] round_idx;
    logic       result_valid;
    logic [9:0] result_time;
    logic [9:0] best_time;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [9:0] t;
        logic       f;
        logic [9:0] b;
    } exp_t;
    exp_t sb_q[$];

    reaction_sequencer #(
        .TICKS_PER_MS(TICKS),
        .ROUNDS(ROUNDS),
        .DELAY_MIN_MS(DMIN)
    ) dut (
        .clk_50M(clk_50M),
        .clear(clear),
        .start(start),
        .stop(stop),
        .counter_value(counter_value),
        .CounterFlag(CounterFlag),
        .LED(LED),
        .foul(foul),
        .round_idx(round_idx),
        .result_valid(result_valid),
        .result_time(result_time),
        .best_time(best_time),
        .done(done)
    );

    always #10 clk_50M = ~clk_50M;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, seed ACE1, one step per clock.
    logic [15:0] m_lfsr;
    always @(posedge clk_50M or negedge clear) begin
        if (!clear) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Start pressed at a falling edge; the FSM accepts it on the 4th rising edge,
    // loading the delay from the LFSR value present just before that edge.
    task automatic press_start(output int delay_ms);
        start = 1'b1;
        repeat (3) @(negedge clk_50M);
        delay_ms = DMIN + int'(m_lfsr[11:0]);
        @(negedge clk_50M);
        start = 1'b0;
    endtask

    // Stop pulse; returns one falling edge before the FSM reacts.
    task automatic press_stop();
        stop = 1'b1;
        repeat (3) @(negedge clk_50M);
        stop = 1'b0;
    endtask

    task automatic push_exp(input logic [9:0] t, input logic f, input logic [9:0] b);
        exp_t e;
        e.t = t;
        e.f = f;
        e.b = b;
        sb_q.push_back(e);
    endtask

    // Wait for one result pulse, compare against the scoreboard, confirm single pulse.
    task automatic wait_result(input string tag);
        bit   seen = 0;
        exp_t e;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk_50M);
            if (result_valid === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s result_timeout got=no_pulse want=pulse", tag);
        end else if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected_result got=pulse want=none", tag);
        end else begin
            e = sb_q.pop_front();
            $display("%s result time=%0d foul=%0d best=%0d", tag, result_time, foul, best_time);
            checks++;
            if (result_time !== e.t) begin
                errors++;
                $display("FAIL %s result_time got=%0d want=%0d", tag, result_time, e.t);
            end
            checks++;
            if (foul !== e.f) begin
                errors++;
                $display("FAIL %s foul got=%0d want=%0d", tag, foul, e.f);
            end
            checks++;
            if (best_time !== e.b) begin
                errors++;
                $display("FAIL %s best_time got=%0d want=%0d", tag, best_time, e.b);
            end
            @(negedge clk_50M);
            checks++;
            if (result_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s single_pulse got=%0d want=0", tag, result_valid);
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        repeat (3) @(negedge clk_50M);
        checks++;
        if (CounterFlag !== 2'b00 || LED !== 1'b0) begin
            errors++;
            $display("FAIL reset_flag_led got=%b/%b want=00/0", CounterFlag, LED);
        end
        checks++;
        if (foul !== 1'b0 || round_idx !== 2'd0 || result_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status got=%b%0d%b%b want=0000", foul, round_idx, result_valid, done);
        end
        checks++;
        if (result_time !== 10'd0 || best_time !== 10'd999) begin
            errors++;
            $display("FAIL reset_times got=%0d/%0d want=0/999", result_time, best_time);
        end
        clear = 1'b1;
        repeat (6) @(negedge clk_50M);
        $display("reset done");
    endtask

    // Start a round and verify the exact pre-light delay and go-light outputs.
    task automatic test_go_light(input string tag, input logic [1:0] exp_round);
        int d;
        press_start(d);
        checks++;
        if (round_idx !== exp_round || foul !== 1'b0) begin
            errors++;
            $display("FAIL %s accept got=round%0d foul%0d want=round%0d foul0", tag, round_idx, foul, exp_round);
        end
        checks++;
        if (CounterFlag !== 2'b00 || LED !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s wait_outputs got=%b/%b/%b want=00/0/0", tag, CounterFlag, LED, done);
        end
        repeat (d * TICKS - 1) @(negedge clk_50M);
        checks++;
        if (LED !== 1'b0) begin
            errors++;
            $display("FAIL %s led_early got=%b want=0", tag, LED);
        end
        @(negedge clk_50M);
        checks++;
        if (LED !== 1'b1 || CounterFlag !== 2'b10) begin
            errors++;
            $display("FAIL %s go_light got=%b/%b want=1/10", tag, LED, CounterFlag);
        end
        $display("%s light after %0d ms", tag, d);
    endtask

    task automatic test_capture(input string tag, input logic [9:0] cv, input logic [9:0] exp_best);
        counter_value = cv;
        push_exp(cv, 1'b0, exp_best);
        press_stop();
        @(negedge clk_50M);
        checks++;
        if (CounterFlag !== 2'b01 || LED !== 1'b0) begin
            errors++;
            $display("FAIL %s capture_outputs got=%b/%b want=01/0", tag, CounterFlag, LED);
        end
        wait_result(tag);
        checks++;
        if (CounterFlag !== 2'b01) begin
            errors++;
            $display("FAIL %s round_end_flag got=%b want=01", tag, CounterFlag);
        end
        counter_value = 10'd0;
    endtask

    task automatic test_timeout(input string tag, input logic [9:0] exp_best);
        push_exp(10'd999, 1'b0, exp_best);
        counter_value = 10'd999;
        wait_result(tag);
        counter_value = 10'd0;
    endtask

    task automatic test_done(input string tag);
        checks++;
        if (done !== 1'b1 || CounterFlag !== 2'b01 || round_idx !== 2'(ROUNDS - 1)) begin
            errors++;
            $display("FAIL %s done got=%b/%b/%0d want=1/01/%0d", tag, done, CounterFlag, round_idx, ROUNDS - 1);
        end
        $display("%s game complete best=%0d", tag, best_time);
    endtask

    // New game from DONE, then an early stop 100 ms into the delay.
    task automatic test_foul(input string tag);
        int d;
        press_start(d);
        checks++;
        if (done !== 1'b0 || round_idx !== 2'd0 || best_time !== 10'd999 || foul !== 1'b0) begin
            errors++;
            $display("FAIL %s new_game got=%b/%0d/%0d/%b want=0/0/999/0", tag, done, round_idx, best_time, foul);
        end
        repeat (100 * TICKS) @(negedge clk_50M);
        push_exp(10'd999, 1'b1, 10'd999);
        press_stop();
        wait_result(tag);
        checks++;
        if (foul !== 1'b1 || LED !== 1'b0 || CounterFlag !== 2'b01) begin
            errors++;
            $display("FAIL %s foul_hold got=%b/%b/%b want=1/0/01", tag, foul, LED, CounterFlag);
        end
    endtask

    task automatic test_clear_mid_timing(input string tag);
        int d;
        int pulses = 0;
        test_go_light(tag, 2'd0);
        start = 1'b1;
        #2 clear = 1'b0;
        #1;
        checks++;
        if (LED !== 1'b0 || CounterFlag !== 2'b00) begin
            errors++;
            $display("FAIL %s async_clear got=%b/%b want=0/00", tag, LED, CounterFlag);
        end
        checks++;
        if (best_time !== 10'd999 || result_time !== 10'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s clear_values got=%0d/%0d/%b want=999/0/0", tag, best_time, result_time, done);
        end
        repeat (2) @(negedge clk_50M);
        clear = 1'b1;
        repeat (10) @(negedge clk_50M);
        // If the held start had been taken, a stop would now register a foul.
        press_stop();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_50M);
            if (result_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || foul !== 1'b0 || CounterFlag !== 2'b00) begin
            errors++;
            $display("FAIL %s held_start got=pulses%0d foul%b want=pulses0 foul0", tag, pulses, foul);
        end
        start = 1'b0;
        repeat (5) @(negedge clk_50M);
        press_start(d);
        repeat (10) @(negedge clk_50M);
        push_exp(10'd999, 1'b1, 10'd999);
        press_stop();
        wait_result(tag);
    endtask

    initial begin
        test_reset();
        test_go_light("g1r0", 2'd0);
        test_capture("g1r0", 10'd250, 10'd250);
        test_go_light("g1r1", 2'd1);
        test_timeout("g1r1", 10'd250);
        test_done("g1");
        test_foul("g2r0");
        test_go_light("g2r1", 2'd1);
        test_capture("g2r1", 10'd180, 10'd180);
        test_done("g2");
        test_clear_mid_timing("g3");
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d want=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
